// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cpu_pkg
// Brief    : Shared opcodes, sequencer states, ALU select codes and flag codes.
// Revision : 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int c_instr_w = 18;
  localparam int c_pc_w    = 18;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_AND  = 4'h1,
    OP_NAND = 4'h2,
    OP_NOR  = 4'h3,
    OP_ADDI = 4'h4,
    OP_ANDI = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_CMP  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JE   = 4'hA,
    OP_JA   = 4'hB,
    OP_JB   = 4'hC,
    OP_JAE  = 4'hD,
    OP_JBE  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_e;

  localparam logic [3:0] c_alu_add  = 4'b0001;
  localparam logic [3:0] c_alu_and  = 4'b0010;
  localparam logic [3:0] c_alu_nand = 4'b0100;
  localparam logic [3:0] c_alu_nor  = 4'b1000;

  localparam logic [1:0] c_flag_above = 2'b00;
  localparam logic [1:0] c_flag_equal = 2'b01;
  localparam logic [1:0] c_flag_below = 2'b10;

  function automatic logic [3:0] alu_code(input opcode_e op);
    case (op)
      OP_ADD, OP_ADDI: alu_code = c_alu_add;
      OP_AND, OP_ANDI: alu_code = c_alu_and;
      OP_NAND:         alu_code = c_alu_nand;
      OP_NOR:          alu_code = c_alu_nor;
      default:         alu_code = 4'b0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_exec_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : fetch_exec_sequencer_if
// Brief    : Control bus between the sequencer (master) and its datapath (slave).
// Revision : 1.0
// ---------------------------------------------------------------------------
interface fetch_exec_sequencer_if;

  logic                          start;
  logic [cpu_pkg::c_instr_w-1:0] instr;
  logic [1:0]                    flags;
  logic                          clr;
  logic                          pc_inc;
  logic                          pc_wrt;
  logic [cpu_pkg::c_pc_w-1:0]    pc_target;
  logic [3:0]                    alu_select;
  logic                          alu_imm;
  logic [3:0]                    r1_addr;
  logic [3:0]                    r2_addr;
  logic [3:0]                    w_addr;
  logic                          regw_enable;
  logic                          wb_sel;
  logic [9:0]                    mem_addr;
  logic                          memwr_enable;
  logic                          flag_wr;
  logic                          busy;
  logic                          halted;

  modport master (
    input  start, instr, flags,
    output clr, pc_inc, pc_wrt, pc_target, alu_select, alu_imm,
           r1_addr, r2_addr, w_addr, regw_enable, wb_sel, mem_addr,
           memwr_enable, flag_wr, busy, halted
  );

  modport slave (
    output start, instr, flags,
    input  clr, pc_inc, pc_wrt, pc_target, alu_select, alu_imm,
           r1_addr, r2_addr, w_addr, regw_enable, wb_sel, mem_addr,
           memwr_enable, flag_wr, busy, halted
  );

endinterface
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : branch_cond
// Brief    : Decides whether a jump opcode is taken given the stored flags.
// Revision : 1.0
// ---------------------------------------------------------------------------
module branch_cond
  import cpu_pkg::*;
(
  input  opcode_e    opcode,
  input  logic [1:0] flags,
  output logic       taken
);

  // Flag code 11 is never produced by the comparator; conditional jumps treat it as not taken.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_JMP:  taken = 1'b1;
      OP_JE:   taken = (flags == c_flag_equal);
      OP_JA:   taken = (flags == c_flag_above);
      OP_JB:   taken = (flags == c_flag_below);
      OP_JAE:  taken = (flags == c_flag_above) || (flags == c_flag_equal);
      OP_JBE:  taken = (flags == c_flag_equal) || (flags == c_flag_below);
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_exec_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : fetch_exec_sequencer
// Brief    : Multi-cycle fetch/decode/execute control FSM for the 18-bit CPU.
// Revision : 1.0
// ---------------------------------------------------------------------------
module fetch_exec_sequencer
  import cpu_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  fetch_exec_sequencer_if.master seq_bus
);

  state_e               r_state;
  state_e               w_state_next;
  logic [c_instr_w-1:0] r_ir;

  opcode_e    w_opcode;
  logic [3:0] w_dst;
  logic [3:0] w_src1;
  logic [3:0] w_src2;
  logic [9:0] w_addr10;
  logic [3:0] w_r1_field;
  logic       w_taken;
  logic       w_is_alu;
  logic       w_is_jump;

  logic                 w_clr, w_pc_inc, w_pc_wrt, w_regw, w_memwr, w_flag_wr;
  logic [3:0]           w_alu_select, w_r1_addr, w_r2_addr, w_wr_addr;
  logic                 w_alu_imm, w_wb_sel;
  logic [9:0]           w_mem_addr;
  logic [c_pc_w-1:0]    w_pc_target;

  assign w_opcode   = opcode_e'(r_ir[17:14]);
  assign w_dst      = r_ir[13:10];
  assign w_src1     = r_ir[9:6];
  assign w_src2     = r_ir[3:0];
  assign w_addr10   = r_ir[9:0];
  assign w_is_alu   = (w_opcode <= OP_ANDI);
  assign w_is_jump  = (w_opcode >= OP_JMP) && (w_opcode <= OP_JBE);
  // ST and CMP read their first operand from the dst field.
  assign w_r1_field = ((w_opcode == OP_ST) || (w_opcode == OP_CMP)) ? w_dst : w_src1;

  branch_cond u_branch_cond (
    .opcode (w_opcode),
    .flags  (seq_bus.flags),
    .taken  (w_taken)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_FETCH) begin
        r_ir <= seq_bus.instr;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_pc_inc     = 1'b0;
    w_pc_wrt     = 1'b0;
    w_regw       = 1'b0;
    w_memwr      = 1'b0;
    w_flag_wr    = 1'b0;
    w_alu_select = 4'b0000;
    w_alu_imm    = 1'b0;
    w_r1_addr    = 4'd0;
    w_r2_addr    = 4'd0;
    w_wr_addr    = 4'd0;
    w_wb_sel     = 1'b0;
    w_mem_addr   = 10'd0;
    w_pc_target  = '0;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (seq_bus.start) begin
          w_clr        = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: w_state_next = S_DECODE;
      S_DECODE: begin
        w_r1_addr    = w_r1_field;
        w_r2_addr    = w_src2;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        // Read addresses stay valid so the registered RegFile output is stable here.
        w_r1_addr    = w_r1_field;
        w_r2_addr    = w_src2;
        w_state_next = S_FETCH;
        if (w_is_alu) begin
          w_alu_select = alu_code(w_opcode);
          w_alu_imm    = (w_opcode == OP_ADDI) || (w_opcode == OP_ANDI);
          w_wr_addr    = w_dst;
          w_regw       = 1'b1;
          w_pc_inc     = 1'b1;
        end else if (w_opcode == OP_ST) begin
          w_mem_addr = w_addr10;
          w_memwr    = 1'b1;
          w_pc_inc   = 1'b1;
        end else if (w_opcode == OP_LD) begin
          w_mem_addr   = w_addr10;
          w_state_next = S_MEM;
        end else if (w_opcode == OP_CMP) begin
          w_flag_wr = 1'b1;
          w_pc_inc  = 1'b1;
        end else if (w_is_jump) begin
          w_pc_target = {{(c_pc_w-10){1'b0}}, w_addr10};
          w_pc_wrt    = w_taken;
          w_pc_inc    = ~w_taken;
        end else begin
          w_state_next = S_HALTED;
        end
      end
      S_MEM: begin
        w_mem_addr   = w_addr10;
        w_state_next = S_WB;
      end
      S_WB: begin
        w_regw       = 1'b1;
        w_wb_sel     = 1'b1;
        w_wr_addr    = w_dst;
        w_pc_inc     = 1'b1;
        w_state_next = S_FETCH;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A reset cycle must never let a strobe escape, even mid-instruction.
  assign seq_bus.clr          = w_clr     & ~reset;
  assign seq_bus.pc_inc       = w_pc_inc  & ~reset;
  assign seq_bus.pc_wrt       = w_pc_wrt  & ~reset;
  assign seq_bus.regw_enable  = w_regw    & ~reset;
  assign seq_bus.memwr_enable = w_memwr   & ~reset;
  assign seq_bus.flag_wr      = w_flag_wr & ~reset;
  assign seq_bus.pc_target    = w_pc_target;
  assign seq_bus.alu_select   = w_alu_select;
  assign seq_bus.alu_imm      = w_alu_imm;
  assign seq_bus.r1_addr      = w_r1_addr;
  assign seq_bus.r2_addr      = w_r2_addr;
  assign seq_bus.w_addr       = w_wr_addr;
  assign seq_bus.wb_sel       = w_wb_sel;
  assign seq_bus.mem_addr     = w_mem_addr;
  assign seq_bus.busy         = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign seq_bus.halted       = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_exec_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_fetch_exec_sequencer
// Brief    : Directed self-checking bench for fetch_exec_sequencer.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_fetch_exec_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fetch_exec_sequencer_if bus ();

  fetch_exec_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .seq_bus (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [5:0] strobes;
  assign strobes = {bus.clr, bus.pc_inc, bus.pc_wrt, bus.regw_enable, bus.memwr_enable, bus.flag_wr};

  // Advance one cycle; inputs are driven and outputs sampled mid-low-phase.
  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1;
    repeat (3) cyc();
    checks++; if (strobes !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b expected %b", strobes, 6'b0); end
    checks++; if ({bus.busy, bus.halted} !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", {bus.busy, bus.halted}); end
    bus.start = 1'b0; reset = 1'b0;
    cyc();
    checks++; if ({bus.alu_select, bus.mem_addr, bus.pc_target, bus.w_addr, bus.r1_addr} !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", {bus.alu_select, bus.mem_addr, bus.pc_target, bus.w_addr, bus.r1_addr}); end
  endtask

  // Leaves the bench at the first FETCH cycle after ADD retires.
  task automatic test_add();
    bus.instr = {4'h0, 4'd1, 4'd2, 2'b00, 4'd3};
    bus.start = 1'b1; #1;
    checks++; if (bus.clr !== 1'b1) begin errors++; $display("FAIL add_clr: got %b expected 1", bus.clr); end
    cyc(); bus.start = 1'b0; #1;
    checks++; if ({bus.clr, bus.busy} !== 2'b01) begin errors++; $display("FAIL add_fetch: got %b expected 01", {bus.clr, bus.busy}); end
    cyc();
    checks++; if ({bus.r1_addr, bus.r2_addr, bus.regw_enable} !== {4'd2, 4'd3, 1'b0}) begin errors++; $display("FAIL add_decode: got %h expected %h", {bus.r1_addr, bus.r2_addr, bus.regw_enable}, {4'd2, 4'd3, 1'b0}); end
    cyc();
    checks++; if ({bus.regw_enable, bus.w_addr, bus.alu_select, bus.pc_inc, bus.pc_wrt, bus.wb_sel, bus.alu_imm} !== {1'b1, 4'd1, 4'b0001, 1'b1, 3'b000}) begin errors++; $display("FAIL add_exec: got %b expected %b", {bus.regw_enable, bus.w_addr, bus.alu_select, bus.pc_inc, bus.pc_wrt, bus.wb_sel, bus.alu_imm}, {1'b1, 4'd1, 4'b0001, 1'b1, 3'b000}); end
    checks++; if (bus.r1_addr !== 4'd2) begin errors++; $display("FAIL add_r1_hold: got %h expected 2", bus.r1_addr); end
    cyc();
    checks++; if ({strobes, bus.busy} !== 7'b0000001) begin errors++; $display("FAIL add_next_fetch: got %b expected 0000001", {strobes, bus.busy}); end
  endtask

  task automatic test_addi();
    int writes;
    writes = 0;
    bus.instr = {4'h4, 4'd4, 4'd4, 6'h3F}; #1;
    writes += int'(bus.regw_enable);
    cyc(); writes += int'(bus.regw_enable);
    cyc(); writes += int'(bus.regw_enable);
    checks++; if ({bus.alu_imm, bus.alu_select, bus.w_addr} !== {1'b1, 4'b0001, 4'd4}) begin errors++; $display("FAIL addi_exec: got %b expected %b", {bus.alu_imm, bus.alu_select, bus.w_addr}, {1'b1, 4'b0001, 4'd4}); end
    cyc(); writes += int'(bus.regw_enable);
    checks++; if (writes !== 1) begin errors++; $display("FAIL addi_write_count: got %0d expected 1", writes); end
  endtask

  task automatic test_ld();
    bus.instr = {4'h6, 4'd5, 10'h3FF}; #1;
    cyc(); cyc();
    checks++; if ({bus.mem_addr, bus.regw_enable, bus.pc_inc} !== {10'h3FF, 2'b00}) begin errors++; $display("FAIL ld_exec: got %h expected %h", {bus.mem_addr, bus.regw_enable, bus.pc_inc}, {10'h3FF, 2'b00}); end
    cyc();
    checks++; if ({bus.mem_addr, strobes} !== {10'h3FF, 6'b0}) begin errors++; $display("FAIL ld_mem: got %h expected %h", {bus.mem_addr, strobes}, {10'h3FF, 6'b0}); end
    cyc();
    checks++; if ({bus.regw_enable, bus.wb_sel, bus.w_addr, bus.pc_inc} !== {2'b11, 4'd5, 1'b1}) begin errors++; $display("FAIL ld_wb: got %b expected %b", {bus.regw_enable, bus.wb_sel, bus.w_addr, bus.pc_inc}, {2'b11, 4'd5, 1'b1}); end
    cyc();
    checks++; if ({strobes, bus.busy} !== 7'b0000001) begin errors++; $display("FAIL ld_next_fetch: got %b expected 0000001", {strobes, bus.busy}); end
  endtask

  task automatic test_st();
    bus.instr = {4'h7, 4'd9, 10'h155}; #1;
    cyc();
    checks++; if (bus.r1_addr !== 4'd9) begin errors++; $display("FAIL st_r1: got %h expected 9", bus.r1_addr); end
    cyc();
    checks++; if ({bus.memwr_enable, bus.mem_addr, bus.pc_inc, bus.regw_enable} !== {1'b1, 10'h155, 2'b10}) begin errors++; $display("FAIL st_exec: got %h expected %h", {bus.memwr_enable, bus.mem_addr, bus.pc_inc, bus.regw_enable}, {1'b1, 10'h155, 2'b10}); end
    cyc();
  endtask

  task automatic test_cmp_je();
    bus.instr = {4'h8, 4'd6, 4'd0, 2'b00, 4'd7}; #1;
    cyc();
    checks++; if ({bus.r1_addr, bus.r2_addr} !== {4'd6, 4'd7}) begin errors++; $display("FAIL cmp_regs: got %h expected 67", {bus.r1_addr, bus.r2_addr}); end
    cyc();
    checks++; if ({bus.flag_wr, bus.pc_inc, bus.regw_enable} !== 3'b110) begin errors++; $display("FAIL cmp_exec: got %b expected 110", {bus.flag_wr, bus.pc_inc, bus.regw_enable}); end
    cyc();
    bus.instr = {4'hA, 4'd0, 10'h010}; bus.flags = 2'b01; #1;
    cyc(); cyc();
    checks++; if ({bus.pc_wrt, bus.pc_inc, bus.pc_target} !== {2'b10, 18'h00010}) begin errors++; $display("FAIL je_taken: got %h expected %h", {bus.pc_wrt, bus.pc_inc, bus.pc_target}, {2'b10, 18'h00010}); end
    cyc();
    bus.flags = 2'b00; #1;
    cyc(); cyc();
    checks++; if ({bus.pc_wrt, bus.pc_inc} !== 2'b01) begin errors++; $display("FAIL je_not_taken: got %b expected 01", {bus.pc_wrt, bus.pc_inc}); end
    cyc();
  endtask

  task automatic test_branch_table();
    logic [3:0] ops   [10] = '{4'h9, 4'hB, 4'hB, 4'hC, 4'hC, 4'hD, 4'hD, 4'hE, 4'hE, 4'hA};
    logic [1:0] flg   [10] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b10};
    logic       taken [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.instr = {ops[i], 4'd0, 10'h2A5}; bus.flags = flg[i]; #1;
      cyc(); cyc();
      checks++; if ({bus.pc_wrt, bus.pc_inc} !== {taken[i], ~taken[i]}) begin errors++; $display("FAIL branch_%0d: got %b expected %b", i, {bus.pc_wrt, bus.pc_inc}, {taken[i], ~taken[i]}); end
      cyc();
    end
  endtask

  task automatic test_reset_mid_ld();
    bus.instr = {4'h6, 4'd5, 10'h3FF}; #1;
    cyc(); cyc(); cyc();
    reset = 1'b1; #1;
    checks++; if (strobes !== 6'b0) begin errors++; $display("FAIL rst_mem_strobes: got %b expected 0", strobes); end
    cyc();
    reset = 1'b0; #1;
    checks++; if ({strobes, bus.busy, bus.mem_addr, bus.w_addr} !== '0) begin errors++; $display("FAIL rst_mem_idle: got %h expected 0", {strobes, bus.busy, bus.mem_addr, bus.w_addr}); end
    cyc();
    checks++; if ({bus.regw_enable, bus.busy} !== 2'b00) begin errors++; $display("FAIL rst_mem_no_wb: got %b expected 00", {bus.regw_enable, bus.busy}); end
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    bus.instr = 18'h3C000; bus.start = 1'b1; #1;
    cyc(); bus.start = 1'b0;
    cyc(); cyc();
    checks++; if (strobes !== 6'b0) begin errors++; $display("FAIL halt_exec: got %b expected 0", strobes); end
    for (int i = 0; i < 10; i++) begin
      cyc();
      if ({bus.halted, bus.busy, strobes} !== 8'b10000000) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles expected 0", bad); end
    bus.start = 1'b1; #1;
    checks++; if (bus.clr !== 1'b1) begin errors++; $display("FAIL halt_restart_clr: got %b expected 1", bus.clr); end
    cyc();
    checks++; if ({bus.busy, bus.halted, bus.clr} !== 3'b100) begin errors++; $display("FAIL halt_restart_fetch: got %b expected 100", {bus.busy, bus.halted, bus.clr}); end
    cyc();
    checks++; if (bus.clr !== 1'b0) begin errors++; $display("FAIL start_while_busy: got %b expected 0", bus.clr); end
    bus.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.instr = '0;
    bus.flags = 2'b00;
    test_reset();
    test_add();
    test_addi();
    test_ld();
    test_st();
    test_cmp_je();
    test_branch_table();
    test_reset_mid_ld();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
